// File: rtl/instr_fetch_prefetch.sv
// Instruction-fetch initiator: issues word reads to the instruction RAM, buffers the
// returned words in a small FIFO and streams them to the core with their byte addresses.
module instr_fetch_prefetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_enable_i,
    input  logic [ADDR_WIDTH-1:0]   boot_addr_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
    output logic                    instr_valid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    input  logic                    instr_ready_i,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic [1:0]              dbg_state_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PAUSE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic                    inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]   inflight_addr_q, inflight_addr_d;

    logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    fifo_nonempty;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    branch_take;
    logic [OCC_W-1:0]        occupancy;
    logic [ADDR_WIDTH-1:0]   boot_aligned;
    logic [ADDR_WIDTH-1:0]   branch_aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign boot_aligned   = boot_addr_i & ~ADDR_WIDTH'(3);
    assign branch_aligned = branch_addr_i & ~ADDR_WIDTH'(3);

    // Core stream: a word transfers on any cycle where instr_valid_o & instr_ready_i;
    // valid never depends on ready, and head data/address are stable while valid & ~ready.
    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && instr_ready_i;
    assign branch_take   = branch_i && (state_q != IDLE);
    assign push          = inflight_q && !branch_take;

    // Reserve a slot for every word already requested so a response can never overflow.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = (state_q == FETCH) && fetch_enable_i && !branch_i
                       && (occupancy < OCC_W'(DEPTH));

    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? fetch_addr_q : inflight_addr_q;
        case (state_q)
            IDLE: begin
                if (fetch_enable_i) begin
                    state_d      = FETCH;
                    fetch_addr_d = boot_aligned;
                end
            end
            FETCH: begin
                if (!fetch_enable_i) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (fetch_enable_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_take) begin
            state_d      = fetch_enable_i ? FETCH : PAUSE;
            fetch_addr_d = branch_aligned;
        end else if (issue) begin
            fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            fetch_addr_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    // A redirect empties the FIFO outright; a pop in the same cycle is subsumed by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (branch_take) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rdata_i;
            addr_mem_q[wr_ptr_q] <= inflight_addr_q;
        end
    end

    assign instr_valid_o = fifo_nonempty;
    assign instr_rdata_o = fifo_nonempty ? data_mem_q[rd_ptr_q] : '0;
    assign instr_addr_o  = fifo_nonempty ? addr_mem_q[rd_ptr_q] : '0;

    assign mem_en_o    = issue;
    assign mem_addr_o  = fetch_addr_q;
    assign mem_we_o    = 1'b0;
    assign mem_be_o    = '1;
    assign busy_o      = (state_q != IDLE) || inflight_q;
    assign dbg_state_o = state_q;

    no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Directed bench for instr_fetch_prefetch: boot, back-pressure, branch, wrap,
// pause/resume and asynchronous reset, against a one-cycle-latency RAM model.
module tb_instr_fetch_prefetch;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_enable = 1'b0;
    logic [AW-1:0]   boot_addr = '0;
    logic            branch = 1'b0;
    logic [AW-1:0]   branch_addr = '0;
    logic            instr_valid;
    logic [DW-1:0]   instr_rdata;
    logic [AW-1:0]   instr_addr;
    logic            instr_ready = 1'b0;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable),
        .boot_addr_i    (boot_addr),
        .branch_i       (branch),
        .branch_addr_i  (branch_addr),
        .instr_valid_o  (instr_valid),
        .instr_rdata_o  (instr_rdata),
        .instr_addr_o   (instr_addr),
        .instr_ready_i  (instr_ready),
        .mem_en_o       (mem_en),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_rdata_i    (mem_rdata),
        .busy_o         (busy),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // RAM wrapper: read data one cycle after the request, junk otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? ram_word(mem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic br, input logic [AW-1:0] ba, input logic rdy);
        @(negedge clk);
        fetch_enable = en;
        branch       = br;
        branch_addr  = ba;
        instr_ready  = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        fetch_enable = 1'b0;
        branch       = 1'b0;
        instr_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] ea;

        // Reset state
        #3;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rdata", instr_rdata, 32'd0);
        check("rst_iaddr", 32'(instr_addr), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'hF);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Boot at 0x8000, one word per cycle
        do_reset();
        boot_addr = 16'h8000;
        step(1, 0, '0, 1);
        check("boot_first_no_req", 32'(mem_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, '0, 1);
            check("boot_req_en", 32'(mem_en), 32'd1);
            check("boot_req_addr", 32'(mem_addr), 32'h8000 + 4 * k);
            if (k >= 2) begin
                check("boot_valid", 32'(instr_valid), 32'd1);
                check("boot_iaddr", 32'(instr_addr), 32'h8000 + 4 * (k - 2));
                check("boot_rdata", instr_rdata, ram_word(16'(32'h8000 + 4 * (k - 2))));
            end else begin
                check("boot_not_valid", 32'(instr_valid), 32'd0);
            end
        end

        // Back-pressure: exactly DEPTH requests, then resume on the first pop
        do_reset();
        boot_addr = 16'h8000;
        step(1, 0, '0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, '0, 0);
            check("bp_req_en", 32'(mem_en), 32'd1);
            check("bp_req_addr", 32'(mem_addr), 32'h8000 + 4 * k);
        end
        for (int k = 0; k < 2; k++) begin
            step(1, 0, '0, 0);
            check("bp_stalled", 32'(mem_en), 32'd0);
            check("bp_head_hold", 32'(instr_addr), 32'h8000);
        end
        for (int k = 0; k < 5; k++) begin
            step(1, 0, '0, 1);
            check("bp_pop_valid", 32'(instr_valid), 32'd1);
            check("bp_pop_iaddr", 32'(instr_addr), 32'h8000 + 4 * k);
            check("bp_reissue_en", 32'(mem_en), 32'd1);
            check("bp_reissue_addr", 32'(mem_addr), 32'h8010 + 4 * k);
        end

        // Branch mid-stream, then back-to-back branches, then a branch while disabled
        do_reset();
        boot_addr = 16'h8000;
        step(1, 0, '0, 1);
        for (int k = 0; k < 5; k++) step(1, 0, '0, 1);
        check("br_pre_addr", 32'(mem_addr), 32'h8010);
        step(1, 1, 16'h0102, 1);
        check("br_cycle_no_req", 32'(mem_en), 32'd0);
        check("br_cycle_head", 32'(instr_addr), 32'h800C);
        step(1, 0, '0, 1);
        check("br_flushed", 32'(instr_valid), 32'd0);
        check("br_first_req_en", 32'(mem_en), 32'd1);
        check("br_first_req", 32'(mem_addr), 32'h0100);
        step(1, 0, '0, 1);
        check("br_still_empty", 32'(instr_valid), 32'd0);
        check("br_second_req", 32'(mem_addr), 32'h0104);
        step(1, 0, '0, 1);
        check("br_first_valid", 32'(instr_valid), 32'd1);
        check("br_first_iaddr", 32'(instr_addr), 32'h0100);
        check("br_first_rdata", instr_rdata, ram_word(16'h0100));
        step(1, 1, 16'h2000, 1);
        check("bb_first_no_req", 32'(mem_en), 32'd0);
        check("bb_head", 32'(instr_addr), 32'h0104);
        step(1, 1, 16'h3006, 1);
        check("bb_second_no_req", 32'(mem_en), 32'd0);
        check("bb_empty_a", 32'(instr_valid), 32'd0);
        step(1, 0, '0, 1);
        check("bb_req", 32'(mem_addr), 32'h3004);
        check("bb_empty_b", 32'(instr_valid), 32'd0);
        step(1, 0, '0, 1);
        check("bb_empty_c", 32'(instr_valid), 32'd0);
        step(1, 0, '0, 1);
        check("bb_valid", 32'(instr_valid), 32'd1);
        check("bb_iaddr", 32'(instr_addr), 32'h3004);
        step(0, 1, 16'h4000, 1);
        check("brp_no_req", 32'(mem_en), 32'd0);
        step(0, 0, '0, 1);
        check("brp_empty", 32'(instr_valid), 32'd0);
        check("brp_paused", 32'(dbg_state), 32'd2);
        step(1, 0, '0, 1);
        check("brp_resume_cycle", 32'(mem_en), 32'd0);
        step(1, 0, '0, 1);
        check("brp_req_en", 32'(mem_en), 32'd1);
        check("brp_req_addr", 32'(mem_addr), 32'h4000);

        // Wrap from 0xFFF8 (unaligned boot), branch in IDLE ignored
        do_reset();
        boot_addr = 16'hFFFA;
        step(1, 1, 16'h4444, 1);
        check("wrap_idle_no_req", 32'(mem_en), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, '0, 1);
            if (k < 4) begin
                ea = 16'hFFF8 + 16'(4 * k);
                check("wrap_req_addr", 32'(mem_addr), 32'(ea));
            end
            if (k >= 2) begin
                ea = 16'hFFF8 + 16'(4 * (k - 2));
                check("wrap_iaddr", 32'(instr_addr), 32'(ea));
            end
        end

        // Pause after the request to 0x8020, resume at 0x8024
        do_reset();
        boot_addr = 16'h8000;
        step(1, 0, '0, 1);
        for (int k = 0; k < 9; k++) step(1, 0, '0, 1);
        check("pause_last_req", 32'(mem_addr), 32'h8020);
        step(0, 0, '0, 1);
        check("pause_no_req", 32'(mem_en), 32'd0);
        check("pause_head", 32'(instr_addr), 32'h801C);
        step(0, 0, '0, 1);
        check("pause_inflight_valid", 32'(instr_valid), 32'd1);
        check("pause_inflight_iaddr", 32'(instr_addr), 32'h8020);
        check("pause_inflight_rdata", instr_rdata, ram_word(16'h8020));
        check("pause_no_req_b", 32'(mem_en), 32'd0);
        step(0, 0, '0, 1);
        check("pause_drained", 32'(instr_valid), 32'd0);
        check("pause_busy", 32'(busy), 32'd1);
        step(1, 0, '0, 1);
        check("resume_cycle_no_req", 32'(mem_en), 32'd0);
        step(1, 0, '0, 1);
        check("resume_req_en", 32'(mem_en), 32'd1);
        check("resume_req_addr", 32'(mem_addr), 32'h8024);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        check("resume_iaddr", 32'(instr_addr), 32'h8024);

        // Asynchronous reset with a request outstanding
        do_reset();
        boot_addr = 16'h8000;
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        check("ar_pre_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid), 32'd0);
        check("ar_rdata", instr_rdata, 32'd0);
        check("ar_iaddr", 32'(instr_addr), 32'd0);
        check("ar_mem_en", 32'(mem_en), 32'd0);
        check("ar_mem_addr", 32'(mem_addr), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        fetch_enable = 1'b0;
        rst_n = 1'b1;
        step(0, 0, '0, 1);
        check("ar_resp_ignored", 32'(instr_valid), 32'd0);
        check("ar_resp_rdata", instr_rdata, 32'd0);
        check("ar_busy_after", 32'(busy), 32'd0);
        step(0, 0, '0, 1);
        check("ar_still_idle", 32'(dbg_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_prefetch.md
Name: instr_fetch_prefetch

Overview:
- Initiator side of the instruction-memory port. Drives en/addr/we/be requests into the instruction RAM wrapper, which returns read data one cycle later.
- Buffers returned words in a small FIFO and presents them to the core as a valid/ready stream, each word paired with its byte address.
- Handles boot start, pause/resume and branch redirect. On a redirect it flushes stale data.

Parameters:
- ADDR_WIDTH, 16, byte-address width (RAM_SIZE 32768 plus one boot-ROM bit); fetch address wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, instruction word width; fixed 32, so the address stride is 4.
- DEPTH, 4, prefetch FIFO entries; legal range 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_enable_i  in  1  1 = issue requests; 0 = pause issue
- boot_addr_i  in  ADDR_WIDTH  first fetch address, sampled on the first enable after reset
- branch_i  in  1  single-cycle redirect strobe
- branch_addr_i  in  ADDR_WIDTH  redirect target, low 2 bits ignored
- instr_valid_o  out  1  FIFO head valid
- instr_rdata_o  out  DATA_WIDTH  head instruction word
- instr_addr_o  out  ADDR_WIDTH  byte address of head word
- instr_ready_i  in  1  core accepts head when valid&ready
- mem_en_o  out  1  RAM request strobe
- mem_addr_o  out  ADDR_WIDTH  word-aligned request address
- mem_we_o  out  1  constant 0
- mem_be_o  out  DATA_WIDTH/8  constant all ones
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en_o
- busy_o  out  1  1 when state!=IDLE or a request is in flight

Behaviour:
- Reset values:
  - state=IDLE, FIFO empty, fetch_addr_q=0, inflight_q=0.
  - All outputs 0: instr_valid_o, instr_rdata_o, instr_addr_o, mem_en_o, mem_addr_o, busy_o.
  - Reset mid-operation discards everything immediately; any RAM response in the next cycle is ignored because inflight_q=0.
- States: IDLE, FETCH, PAUSE.
  - IDLE -> FETCH when fetch_enable_i=1; fetch_addr_q <= {boot_addr_i[ADDR_WIDTH-1:2],2'b00}. No request is issued in that cycle.
  - FETCH -> PAUSE when fetch_enable_i=0.
  - PAUSE -> FETCH when fetch_enable_i=1; fetch resumes at fetch_addr_q (boot_addr_i is not resampled).
- Issue rule (combinational):
  - mem_en_o = (state==FETCH) & fetch_enable_i & ~branch_i & (count + inflight_q - pop < DEPTH), where pop = instr_valid_o & instr_ready_i.
  - mem_addr_o = fetch_addr_q.
  - On issue: fetch_addr_q += 4 (wraps), and inflight_q <= 1 in the next cycle, otherwise 0.
- Response capture: when inflight_q=1, mem_rdata_i and its request address are pushed into the FIFO that cycle. Space is guaranteed by the issue rule; overflow is illegal (assert).
- Output:
  - instr_valid_o = FIFO non-empty; data and address come from the head.
  - Latency: request in cycle t, response t+1, instr_valid_o in t+2.
  - Push and pop in the same cycle are both honoured, and count is unchanged.
  - With DEPTH>=2 and instr_ready_i held at 1, throughput is one word per cycle.
- Branch (branch_i=1, in any state except IDLE):
  - FIFO flushed in the same cycle; instr_valid_o=0 next cycle.
  - The response arriving in the branch cycle is discarded.
  - No request is issued in the branch cycle.
  - fetch_addr_q <= aligned branch_addr_i.
  - State goes to FETCH if fetch_enable_i=1, else PAUSE.
  - The first request is issued at t+1 and its word is valid at t+3.
  - branch_i in IDLE is ignored.
- Branch plus pop in the same cycle: the pop is accepted and the flush wins.
- Back-to-back branches: the last target wins; no stale word is ever delivered.
- Pause: a response already in flight is still captured; FIFO contents remain poppable.

Test Plan:
- Boot: reset, boot_addr_i=0x8000, enable, ready=1 -> mem_addr_o sequence 0x8000, 0x8004, 0x8008…; instr_addr_o matches each word 2 cycles after its request; throughput 1 per cycle.
- Back-pressure: ready=0 after enable -> exactly DEPTH=4 requests issued, then mem_en_o=0; set ready=1 -> words 0x8000..0x800C pop in order, and issue restarts the same cycle as the first pop.
- Branch: stream at 0x8010, pulse branch_i with branch_addr_i=0x0102 -> the response in the branch cycle is dropped, FIFO emptied, mem_en_o=0 in the branch cycle, next request 0x0100, first delivered word has instr_addr_o=0x0100.
- Wrap: boot_addr_i=0xFFF8 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Pause/resume: drop fetch_enable_i mid-stream after a request to 0x8020 -> that word is still delivered, no further requests; re-enable -> resumes at 0x8024.
- Async reset mid-stream with a request outstanding -> all outputs 0 immediately, the following RAM data is ignored, busy_o=0.
